// File: rtl/abstract_cmd_ctrl_pkg.sv
// Shared definitions for abstract command sequencing: cmderr codes,
// cmdtype codes, command-word field extractors and register-number limits.
// Imported by abstract_cmd_ctrl and abstract_cmd_check.
package abstract_cmd_ctrl_pkg;

   // cmderr codes as seen by the debugger
   localparam logic [2:0] CMDERR_NONE          = 3'd0;
   localparam logic [2:0] CMDERR_BUSY          = 3'd1;
   localparam logic [2:0] CMDERR_NOT_SUPPORTED = 3'd2;
   localparam logic [2:0] CMDERR_EXCEPTION     = 3'd3;
   localparam logic [2:0] CMDERR_HALT_RESUME   = 3'd4;

   // cmdtype codes
   localparam logic [7:0] CMDTYPE_ACCESS_REG   = 8'd0;
   localparam logic [7:0] CMDTYPE_QUICK_ACCESS = 8'd1;
   localparam logic [7:0] CMDTYPE_ACCESS_MEM   = 8'd2;

   // only 32-bit register accesses are implemented
   localparam logic [2:0] AARSIZE_32 = 3'd2;

   // regno windows reachable by an access-register transfer
   localparam logic [15:0] REGNO_CSR_HI = 16'h0FFF;
   localparam logic [15:0] REGNO_GPR_LO = 16'h1000;
   localparam logic [15:0] REGNO_GPR_HI = 16'h101F;

   function automatic logic [7:0] cmd_cmdtype(input logic [31:0] c);
      return c[31:24];
   endfunction

   function automatic logic [2:0] cmd_aarsize(input logic [31:0] c);
      return c[22:20];
   endfunction

   function automatic logic cmd_postexec(input logic [31:0] c);
      return c[18];
   endfunction

   function automatic logic cmd_transfer(input logic [31:0] c);
      return c[17];
   endfunction

   function automatic logic [15:0] cmd_regno(input logic [31:0] c);
      return c[15:0];
   endfunction

endpackage

// File: rtl/abstract_cmd_check.sv
// Combinational validation of an abstract command word.
// Ports: cmd (command word) -> supported (command can be executed),
//        skip_exec (access-register without transfer: no core op, postexec only).
module abstract_cmd_check
   import abstract_cmd_ctrl_pkg::*;
(
   input  logic [31:0] cmd,
   output logic        supported,
   output logic        skip_exec
);

   logic [7:0]  cmdtype;
   logic [2:0]  aarsize;
   logic        transfer;
   logic [15:0] regno;
   logic        regno_ok;

   always_comb begin
      cmdtype  = cmd_cmdtype(cmd);
      aarsize  = cmd_aarsize(cmd);
      transfer = cmd_transfer(cmd);
      regno    = cmd_regno(cmd);

      // CSR window starts at 0, so only its upper bound needs checking
      regno_ok = (regno <= REGNO_CSR_HI) ||
                 ((regno >= REGNO_GPR_LO) && (regno <= REGNO_GPR_HI));

      supported = 1'b0;
      skip_exec = 1'b0;
      if (cmdtype == CMDTYPE_ACCESS_REG) begin
         supported = (aarsize == AARSIZE_32) && (!transfer || regno_ok);
         skip_exec = !transfer;
      end else if (cmdtype == CMDTYPE_ACCESS_MEM) begin
         supported = (aarsize <= AARSIZE_32);
      end
   end

endmodule

// File: rtl/abstract_cmd_ctrl.sv
// Sequences DM abstract commands into the halted core: validate, wait for the
// instruction boundary, drive abstract/abs_cmd until done, optionally run progbuf.
// Ports: clk/rst; cmd_valid/cmd/cmderr_clear from DM; halted/core_ready/core_done/
//        core_exception/progbuf_done from core; abstract/abs_cmd/progbuf_start to
//        core; busy/cmderr to DM. All outputs registered.
module abstract_cmd_ctrl
   import abstract_cmd_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 1024
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [31:0] cmd,
   input  logic [2:0]  cmderr_clear,
   input  logic        halted,
   input  logic        core_ready,
   input  logic        core_done,
   input  logic        core_exception,
   input  logic        progbuf_done,
   output logic        abstract,
   output logic [31:0] abs_cmd,
   output logic        progbuf_start,
   output logic        busy,
   output logic [2:0]  cmderr
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_CORE = 2'd1,
      S_EXEC      = 2'd2,
      S_PROGBUF   = 2'd3
   } state_t;

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      abs_cmd_d;
   logic             skip_q, skip_d;
   logic [2:0]       cmderr_d, cmderr_cleared, err_code;
   logic             err_set;
   logic             timed_out;
   logic             supported, skip_exec;

   abstract_cmd_check u_check (
      .cmd       (cmd),
      .supported (supported),
      .skip_exec (skip_exec)
   );

   always_comb begin
      state_d   = state_q;
      abs_cmd_d = abs_cmd;
      skip_d    = skip_q;
      err_set   = 1'b0;
      err_code  = CMDERR_NONE;
      timed_out = (cnt_q == CNT_LAST);

      if (state_q == S_IDLE) begin
         if (cmd_valid && (cmderr == CMDERR_NONE)) begin
            if (!supported) begin
               err_set  = 1'b1;
               err_code = CMDERR_NOT_SUPPORTED;
            end else if (!halted) begin
               err_set  = 1'b1;
               err_code = CMDERR_HALT_RESUME;
            end else begin
               abs_cmd_d = cmd;
               skip_d    = skip_exec;
               state_d   = S_WAIT_CORE;
            end
         end
      end else begin
         // a command written while one runs is dropped; any abort code
         // assigned below takes precedence in the same cycle
         if (cmd_valid) begin
            err_set  = 1'b1;
            err_code = CMDERR_BUSY;
         end

         if (!halted) begin
            state_d  = S_IDLE;
            err_set  = 1'b1;
            err_code = CMDERR_HALT_RESUME;
         end else if (state_q == S_WAIT_CORE) begin
            if (core_ready) begin
               if (!skip_q)
                  state_d = S_EXEC;
               else if (cmd_postexec(abs_cmd))
                  state_d = S_PROGBUF;
               else
                  state_d = S_IDLE;
            end
         end else if (state_q == S_EXEC) begin
            // exception outranks a simultaneous done; done outranks timeout
            if (core_exception) begin
               state_d  = S_IDLE;
               err_set  = 1'b1;
               err_code = CMDERR_EXCEPTION;
            end else if (core_done) begin
               state_d = cmd_postexec(abs_cmd) ? S_PROGBUF : S_IDLE;
            end else if (timed_out) begin
               state_d  = S_IDLE;
               err_set  = 1'b1;
               err_code = CMDERR_EXCEPTION;
            end
         end else begin
            if (core_exception) begin
               state_d  = S_IDLE;
               err_set  = 1'b1;
               err_code = CMDERR_EXCEPTION;
            end else if (progbuf_done) begin
               state_d = S_IDLE;
            end else if (timed_out) begin
               state_d  = S_IDLE;
               err_set  = 1'b1;
               err_code = CMDERR_EXCEPTION;
            end
         end
      end

      // clear first, then a set lands only if the cleared value is zero
      cmderr_cleared = cmderr & ~cmderr_clear;
      cmderr_d       = (err_set && (cmderr_cleared == CMDERR_NONE)) ? err_code
                                                                     : cmderr_cleared;

      // counter restarts on every state entry and only runs in EXEC/PROGBUF
      if (state_d != state_q)
         cnt_d = '0;
      else if ((state_q == S_EXEC) || (state_q == S_PROGBUF))
         cnt_d = cnt_q + 1'b1;
      else
         cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         abs_cmd       <= '0;
         skip_q        <= 1'b0;
         cmderr        <= CMDERR_NONE;
         abstract      <= 1'b0;
         busy          <= 1'b0;
         progbuf_start <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         abs_cmd       <= abs_cmd_d;
         skip_q        <= skip_d;
         cmderr        <= cmderr_d;
         abstract      <= (state_d == S_EXEC);
         busy          <= (state_d != S_IDLE);
         progbuf_start <= (state_d == S_PROGBUF) && (state_q != S_PROGBUF);
      end
   end

endmodule

// File: tb/tb_abstract_cmd_ctrl.sv
module tb_abstract_cmd_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [31:0] cmd;
   logic [2:0]  cmderr_clear;
   logic        halted;
   logic        core_ready;
   logic        core_done;
   logic        core_exception;
   logic        progbuf_done;
   logic        abstract;
   logic [31:0] abs_cmd;
   logic        progbuf_start;
   logic        busy;
   logic [2:0]  cmderr;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   abstract_cmd_ctrl #(.TIMEOUT(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd            (cmd),
      .cmderr_clear   (cmderr_clear),
      .halted         (halted),
      .core_ready     (core_ready),
      .core_done      (core_done),
      .core_exception (core_exception),
      .progbuf_done   (progbuf_done),
      .abstract       (abstract),
      .abs_cmd        (abs_cmd),
      .progbuf_start  (progbuf_start),
      .busy           (busy),
      .cmderr         (cmderr)
   );

   typedef struct {
      string       name;
      logic [31:0] cmd;
      logic        halted;
      logic [2:0]  exp_cmderr;
      logic        exp_busy;
   } vec_t;

   function automatic logic [31:0] mk(input logic [7:0] ctype, input logic [2:0] size,
                                      input logic post, input logic xfer,
                                      input logic wr, input logic [15:0] regno);
      logic [31:0] c;
      c        = '0;
      c[31:24] = ctype;
      c[22:20] = size;
      c[18]    = post;
      c[17]    = xfer;
      c[16]    = wr;
      c[15:0]  = regno;
      return c;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clear_err();
      cmderr_clear = 3'b111;
      step();
      cmderr_clear = 3'b000;
   endtask

   vec_t vecs[10];
   logic [31:0] gpr_rd, csr_wr_pe, skip_pe, other;
   int  ab_cnt;

   initial begin
      gpr_rd    = mk(8'd0, 3'd2, 1'b0, 1'b1, 1'b0, 16'h1005);
      csr_wr_pe = mk(8'd0, 3'd2, 1'b1, 1'b1, 1'b1, 16'h0300);
      skip_pe   = mk(8'd0, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0000);
      other     = mk(8'd2, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0000);

      vecs[0] = '{"gpr_ok",       mk(8'd0, 3'd2, 1'b0, 1'b1, 1'b0, 16'h1005), 1'b1, 3'd0, 1'b1};
      vecs[1] = '{"aarsize3",     mk(8'd0, 3'd3, 1'b0, 1'b1, 1'b0, 16'h1005), 1'b1, 3'd2, 1'b0};
      vecs[2] = '{"cmdtype1",     mk(8'd1, 3'd2, 1'b0, 1'b0, 1'b0, 16'h0000), 1'b1, 3'd2, 1'b0};
      vecs[3] = '{"regno_1020",   mk(8'd0, 3'd2, 1'b0, 1'b1, 1'b0, 16'h1020), 1'b1, 3'd2, 1'b0};
      vecs[4] = '{"csr_0fff",     mk(8'd0, 3'd2, 1'b0, 1'b1, 1'b1, 16'h0FFF), 1'b1, 3'd0, 1'b1};
      vecs[5] = '{"noxfer_2000",  mk(8'd0, 3'd2, 1'b0, 1'b0, 1'b0, 16'h2000), 1'b1, 3'd0, 1'b1};
      vecs[6] = '{"mem_size2",    mk(8'd2, 3'd2, 1'b0, 1'b0, 1'b0, 16'h0000), 1'b1, 3'd0, 1'b1};
      vecs[7] = '{"mem_size3",    mk(8'd2, 3'd3, 1'b0, 1'b0, 1'b0, 16'h0000), 1'b1, 3'd2, 1'b0};
      vecs[8] = '{"cmdtype3",     mk(8'd3, 3'd2, 1'b0, 1'b0, 1'b0, 16'h0000), 1'b1, 3'd2, 1'b0};
      vecs[9] = '{"not_halted",   mk(8'd0, 3'd2, 1'b0, 1'b1, 1'b0, 16'h1005), 1'b0, 3'd4, 1'b0};

      rst = 1'b1; cmd_valid = 0; cmd = '0; cmderr_clear = '0; halted = 1'b1;
      core_ready = 0; core_done = 0; core_exception = 0; progbuf_done = 0;
      step(); step();
      chk("rst_abstract", {31'd0, abstract}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_cmderr", {29'd0, cmderr}, 32'd0);
      chk("rst_abs_cmd", abs_cmd, 32'd0);
      chk("rst_pb_start", {31'd0, progbuf_start}, 32'd0);
      rst = 1'b0;
      step();

      // validation table, core_ready low so accepted commands park in WAIT_CORE
      for (int i = 0; i < 10; i++) begin
         cmd = vecs[i].cmd; halted = vecs[i].halted; cmd_valid = 1'b1;
         step();
         cmd_valid = 1'b0; halted = 1'b1;
         chk({vecs[i].name, "_cmderr"}, {29'd0, cmderr}, {29'd0, vecs[i].exp_cmderr});
         chk({vecs[i].name, "_busy"}, {31'd0, busy}, {31'd0, vecs[i].exp_busy});
         if (vecs[i].exp_busy) begin
            chk({vecs[i].name, "_abs_cmd"}, abs_cmd, vecs[i].cmd);
            halted = 1'b0;   // abort by leaving debug mode
            step();
            halted = 1'b1;
            chk({vecs[i].name, "_halt_abort_busy"}, {31'd0, busy}, 32'd0);
            chk({vecs[i].name, "_halt_abort_err"}, {29'd0, cmderr}, 32'd4);
         end
         clear_err();
         chk({vecs[i].name, "_cleared"}, {29'd0, cmderr}, 32'd0);
      end

      // GPR read: abstract high exactly 3 cycles
      core_ready = 1'b1; cmd = gpr_rd; cmd_valid = 1'b1;
      step(); cmd_valid = 1'b0;
      chk("a_busy_n1", {31'd0, busy}, 32'd1);
      chk("a_abstract_n1", {31'd0, abstract}, 32'd0);
      step(); chk("a_abstract_c1", {31'd0, abstract}, 32'd1);
      step(); chk("a_abstract_c2", {31'd0, abstract}, 32'd1);
      step(); chk("a_abstract_c3", {31'd0, abstract}, 32'd1);
      core_done = 1'b1;
      step(); core_done = 1'b0;
      chk("a_abstract_off", {31'd0, abstract}, 32'd0);
      chk("a_busy_off", {31'd0, busy}, 32'd0);
      chk("a_cmderr", {29'd0, cmderr}, 32'd0);
      chk("a_no_pb", {31'd0, progbuf_start}, 32'd0);

      // CSR write with postexec
      cmd = csr_wr_pe; cmd_valid = 1'b1;
      step(); cmd_valid = 1'b0;
      step(); chk("b_abstract", {31'd0, abstract}, 32'd1);
      core_done = 1'b1;
      step(); core_done = 1'b0;
      chk("b_pb_start", {31'd0, progbuf_start}, 32'd1);
      chk("b_abstract_off", {31'd0, abstract}, 32'd0);
      chk("b_busy_pb", {31'd0, busy}, 32'd1);
      step(); chk("b_pb_start_1cyc", {31'd0, progbuf_start}, 32'd0);
      step(); chk("b_busy_hold", {31'd0, busy}, 32'd1);
      progbuf_done = 1'b1;
      step(); progbuf_done = 1'b0;
      chk("b_busy_off", {31'd0, busy}, 32'd0);
      chk("b_cmderr", {29'd0, cmderr}, 32'd0);

      // skip-exec with postexec: straight to progbuf, never abstract
      cmd = skip_pe; cmd_valid = 1'b1;
      step(); cmd_valid = 1'b0;
      step();
      chk("s_pb_start", {31'd0, progbuf_start}, 32'd1);
      chk("s_abstract", {31'd0, abstract}, 32'd0);
      progbuf_done = 1'b1;
      step(); progbuf_done = 1'b0;
      chk("s_busy_off", {31'd0, busy}, 32'd0);

      // second command while busy, then third ignored until cleared
      cmd = gpr_rd; cmd_valid = 1'b1;
      step(); cmd_valid = 1'b0;
      step();
      cmd = other; cmd_valid = 1'b1;
      step(); cmd_valid = 1'b0;
      chk("c_cmderr_busy", {29'd0, cmderr}, 32'd1);
      chk("c_still_exec", {31'd0, abstract}, 32'd1);
      chk("c_abs_cmd_kept", abs_cmd, gpr_rd);
      core_done = 1'b1;
      step(); core_done = 1'b0;
      chk("c_first_done", {31'd0, busy}, 32'd0);
      cmd = gpr_rd; cmd_valid = 1'b1;
      step(); cmd_valid = 1'b0;
      chk("c_third_ignored", {31'd0, busy}, 32'd0);
      chk("c_cmderr_sticky", {29'd0, cmderr}, 32'd1);
      clear_err();
      chk("c_cleared", {29'd0, cmderr}, 32'd0);
      cmd_valid = 1'b1;
      step(); cmd_valid = 1'b0;
      chk("c_accept_after_clear", {31'd0, busy}, 32'd1);
      step(); core_done = 1'b1;
      step(); core_done = 1'b0;
      chk("c_drain", {31'd0, busy}, 32'd0);

      // simultaneous done and exception: exception wins, no progbuf
      cmd = csr_wr_pe; cmd_valid = 1'b1;
      step(); cmd_valid = 1'b0;
      step(); core_done = 1'b1; core_exception = 1'b1;
      step(); core_done = 1'b0; core_exception = 1'b0;
      chk("f_cmderr", {29'd0, cmderr}, 32'd3);
      chk("f_busy", {31'd0, busy}, 32'd0);
      chk("f_no_pb", {31'd0, progbuf_start}, 32'd0);
      clear_err();

      // timeout: no completion, EXEC lasts TIMEOUT cycles
      cmd = gpr_rd; cmd_valid = 1'b1;
      step(); cmd_valid = 1'b0;
      ab_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (abstract) ab_cnt++;
         else if (ab_cnt > 0) break;
      end
      chk("d_exec_cycles", ab_cnt, 32'd16);
      chk("d_cmderr", {29'd0, cmderr}, 32'd3);
      chk("d_busy", {31'd0, busy}, 32'd0);
      clear_err();

      // async reset while in PROGBUF
      cmd = csr_wr_pe; cmd_valid = 1'b1;
      step(); cmd_valid = 1'b0;
      step(); core_done = 1'b1;
      step(); core_done = 1'b0;
      step();
      chk("e_in_pb_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("e_rst_busy", {31'd0, busy}, 32'd0);
      chk("e_rst_abs_cmd", abs_cmd, 32'd0);
      chk("e_rst_abstract", {31'd0, abstract}, 32'd0);
      chk("e_rst_pb", {31'd0, progbuf_start}, 32'd0);
      step(); rst = 1'b0;
      step();
      chk("e_post_rst_pb", {31'd0, progbuf_start}, 32'd0);
      chk("e_post_rst_cmderr", {29'd0, cmderr}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
